// File: rtl/present80_ks_if.sv
// Handshake bundle between the PRESENT-80 key schedule and its controller/round datapath.
// The dec signal exists only when PRESENT_KS_INVERSE_EN is defined.
interface present80_ks_if;
    logic [79:0] key_in;
    logic        start;
`ifdef PRESENT_KS_INVERSE_EN
    logic        dec;
`endif
    logic        ready;
    logic        rk_valid;
    logic [63:0] rk;
    logic [5:0]  round;
    logic        rk_ack;
    logic        done;

`ifdef PRESENT_KS_INVERSE_EN
    modport master (output key_in, start, dec, rk_ack,
                    input  ready, rk_valid, rk, round, done);
    modport slave  (input  key_in, start, dec, rk_ack,
                    output ready, rk_valid, rk, round, done);
`else
    modport master (output key_in, start, rk_ack,
                    input  ready, rk_valid, rk, round, done);
    modport slave  (input  key_in, start, rk_ack,
                    output ready, rk_valid, rk, round, done);
`endif
endinterface

// File: rtl/present80_key_schedule.sv
// Sequential PRESENT-80 key schedule emitting K1..K32 over a valid/ack handshake.
// Define PRESENT_KS_INVERSE_EN to add the dec input and the reverse (K32..K1) schedule.
module present80_key_schedule (
    input logic          clk,
    input logic          reset,
    present80_ks_if.slave ks
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state;
    logic [79:0] key_reg;
    logic [5:0]  rnd;
    logic        done_r;
    logic        last;
    logic [79:0] key_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

`ifdef PRESENT_KS_INVERSE_EN
    logic       dec_r;
    logic [5:0] rnd_m1;

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    // Reverse schedule walks rnd down; the counter applied is that of the step being undone.
    always_comb begin
        rnd_m1   = rnd - 6'd1;
        last     = dec_r ? (rnd == 6'd1) : (rnd == 6'd32);
        key_next = dec_r ? inv_update(key_reg, rnd_m1[4:0]) : fwd_update(key_reg, rnd[4:0]);
    end
`else
    always_comb begin
        last     = (rnd == 6'd32);
        key_next = fwd_update(key_reg, rnd[4:0]);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= StIdle;
            key_reg <= '0;
            rnd     <= '0;
            done_r  <= 1'b0;
`ifdef PRESENT_KS_INVERSE_EN
            dec_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                StIdle: begin
                    if (ks.start) begin
                        state   <= StRun;
                        key_reg <= ks.key_in;
`ifdef PRESENT_KS_INVERSE_EN
                        dec_r   <= ks.dec;
                        rnd     <= ks.dec ? 6'd32 : 6'd1;
`else
                        rnd     <= 6'd1;
`endif
                    end
                end
                StRun: begin
                    if (ks.rk_ack) begin
                        if (last) begin
                            // Key register is left as-is so rk/round keep the final values.
                            state  <= StIdle;
                            done_r <= 1'b1;
                        end else begin
                            key_reg <= key_next;
`ifdef PRESENT_KS_INVERSE_EN
                            rnd     <= dec_r ? rnd - 6'd1 : rnd + 6'd1;
`else
                            rnd     <= rnd + 6'd1;
`endif
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign ks.ready    = (state == StIdle);
    assign ks.rk_valid = (state == StRun);
    assign ks.rk       = key_reg[79:16];
    assign ks.round    = rnd;
    assign ks.done     = done_r;

endmodule

// File: tb/tb_present80_key_schedule.sv
// Directed self-checking bench for present80_key_schedule; covers the reverse schedule
// when PRESENT_KS_INVERSE_EN is defined.
module tb_present80_key_schedule;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    present80_ks_if ks ();

    present80_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks)
    );

    always #5 clk = ~clk;

    localparam logic [79:0] KeyA = 80'h0123_4567_89AB_CDEF_FEDC;

    logic [3:0]  sbox_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                   4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [63:0] hand_rk [3]  = '{64'h0000_0000_0000_0000, 64'hC000_0000_0000_0000,
                                  64'h5000_1800_0000_0001};
    logic [63:0] fwd_rk  [33];
    logic [79:0] final_state;

    function automatic logic [79:0] model_fwd(input logic [79:0] k, input int r);
        logic [79:0] t;
        logic [4:0]  rc;
        rc        = r[4:0];
        t         = (k << 61) | (k >> 19);
        t[79:76]  = sbox_tbl[t[79:76]];
        t[19:15]  = t[19:15] ^ rc;
        return t;
    endfunction

    task automatic drive_idle();
        ks.key_in = '0;
        ks.start  = 1'b0;
        ks.rk_ack = 1'b0;
`ifdef PRESENT_KS_INVERSE_EN
        ks.dec    = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk} !== {3'b010, 6'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_held: got v/r/d=%b%b%b round=%0d rk=%h, want 010 round=0 rk=0",
                     ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk} !== {3'b010, 6'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_release: got v/r/d=%b%b%b round=%0d rk=%h, want 010 round=0 rk=0",
                     ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk);
        end
    endtask

    task automatic test_forward_zero();
        logic [79:0] mk = '0;
        ks.key_in = '0;
        ks.start  = 1'b1;
        ks.rk_ack = 1'b1;
        for (int r = 1; r <= 32; r++) begin
            @(negedge clk);
            ks.start = 1'b0;
            checks++;
            if ({ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk} !==
                {3'b100, 6'(r), mk[79:16]}) begin
                errors++;
                $display("FAIL fwd_zero_r%0d: got v/r/d=%b%b%b round=%0d rk=%h, want 100 round=%0d rk=%h",
                         r, ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk, r, mk[79:16]);
            end
            if (r <= 3) begin
                checks++;
                if (ks.rk !== hand_rk[r-1]) begin
                    errors++;
                    $display("FAIL fwd_zero_hand_K%0d: got %h want %h", r, ks.rk, hand_rk[r-1]);
                end
            end
            if (r < 32) mk = model_fwd(mk, r);
        end
        @(negedge clk);
        ks.rk_ack = 1'b0;
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done} !== 3'b011) begin
            errors++;
            $display("FAIL fwd_zero_done: got v/r/d=%b%b%b want 011",
                     ks.rk_valid, ks.ready, ks.done);
        end
        @(negedge clk);
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done} !== 3'b010) begin
            errors++;
            $display("FAIL fwd_zero_done_once: got v/r/d=%b%b%b want 010",
                     ks.rk_valid, ks.ready, ks.done);
        end
    endtask

    task automatic test_backpressure();
        ks.key_in = '0;
        ks.start  = 1'b1;
        ks.rk_ack = 1'b0;
        @(negedge clk);
        ks.start  = 1'b0;
        ks.rk_ack = 1'b1;
        checks++;
        if (ks.round !== 6'd1 || ks.rk !== 64'd0) begin
            errors++;
            $display("FAIL bp_K1: got round=%0d rk=%h want round=1 rk=0", ks.round, ks.rk);
        end
        @(negedge clk);
        ks.rk_ack = 1'b0;
        ks.start  = 1'b1;
        ks.key_in = 80'hFFFF_EEEE_DDDD_CCCC_BBBB;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({ks.rk_valid, ks.ready, ks.round, ks.rk} !==
                {2'b10, 6'd2, 64'hC000_0000_0000_0000}) begin
                errors++;
                $display("FAIL bp_stall: got v/r=%b%b round=%0d rk=%h want 10 round=2 rk=c000000000000000",
                         ks.rk_valid, ks.ready, ks.round, ks.rk);
            end
        end
        ks.start  = 1'b0;
        ks.key_in = '0;
        ks.rk_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (ks.round !== 6'd3 || ks.rk !== 64'h5000_1800_0000_0001) begin
            errors++;
            $display("FAIL bp_K3: got round=%0d rk=%h want round=3 rk=5000180000000001",
                     ks.round, ks.rk);
        end
    endtask

    task automatic test_reset_abort();
        repeat (7) @(negedge clk);
        checks++;
        if (ks.round !== 6'd10) begin
            errors++;
            $display("FAIL abort_reach_r10: got round=%0d want 10", ks.round);
        end
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        ks.rk_ack = 1'b0;
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk} !== {3'b010, 6'd0, 64'd0}) begin
            errors++;
            $display("FAIL abort_idle: got v/r/d=%b%b%b round=%0d rk=%h want 010 round=0 rk=0",
                     ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk);
        end
        @(negedge clk);
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done} !== 3'b010) begin
            errors++;
            $display("FAIL abort_no_done: got v/r/d=%b%b%b want 010",
                     ks.rk_valid, ks.ready, ks.done);
        end
        ks.start  = 1'b1;
        ks.rk_ack = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            ks.start = 1'b0;
            checks++;
            if (ks.round !== 6'(r) || ks.rk !== hand_rk[r-1]) begin
                errors++;
                $display("FAIL abort_restart_K%0d: got round=%0d rk=%h want round=%0d rk=%h",
                         r, ks.round, ks.rk, r, hand_rk[r-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] mk = KeyA;
        repeat (29) @(negedge clk);
        checks++;
        if (ks.round !== 6'd32 || ks.rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reach_r32: got round=%0d valid=%b want 32/1", ks.round, ks.rk_valid);
        end
        @(negedge clk);
        checks++;
        if ({ks.ready, ks.done} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_done: got ready/done=%b%b want 11", ks.ready, ks.done);
        end
        ks.start  = 1'b1;
        ks.key_in = KeyA;
        for (int r = 1; r <= 32; r++) begin
            @(negedge clk);
            ks.start = 1'b0;
            checks++;
            if ({ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk} !==
                {3'b100, 6'(r), mk[79:16]}) begin
                errors++;
                $display("FAIL b2b_r%0d: got v/r/d=%b%b%b round=%0d rk=%h want 100 round=%0d rk=%h",
                         r, ks.rk_valid, ks.ready, ks.done, ks.round, ks.rk, r, mk[79:16]);
            end
            fwd_rk[r] = mk[79:16];
            if (r < 32) mk = model_fwd(mk, r);
        end
        final_state = mk;
        @(negedge clk);
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done} !== 3'b011) begin
            errors++;
            $display("FAIL b2b_final_done: got v/r/d=%b%b%b want 011",
                     ks.rk_valid, ks.ready, ks.done);
        end
    endtask

`ifdef PRESENT_KS_INVERSE_EN
    task automatic test_inverse();
        ks.start  = 1'b1;
        ks.dec    = 1'b1;
        ks.key_in = final_state;
        ks.rk_ack = 1'b1;
        for (int r = 32; r >= 1; r--) begin
            @(negedge clk);
            ks.start = 1'b0;
            ks.dec   = 1'b0;
            checks++;
            if ({ks.rk_valid, ks.done, ks.round, ks.rk} !== {2'b10, 6'(r), fwd_rk[r]}) begin
                errors++;
                $display("FAIL inv_r%0d: got v/d=%b%b round=%0d rk=%h want 10 round=%0d rk=%h",
                         r, ks.rk_valid, ks.done, ks.round, ks.rk, r, fwd_rk[r]);
            end
        end
        checks++;
        if (ks.rk !== KeyA[79:16]) begin
            errors++;
            $display("FAIL inv_K1_master: got %h want %h", ks.rk, KeyA[79:16]);
        end
        @(negedge clk);
        ks.rk_ack = 1'b0;
        checks++;
        if ({ks.rk_valid, ks.ready, ks.done} !== 3'b011) begin
            errors++;
            $display("FAIL inv_done: got v/r/d=%b%b%b want 011",
                     ks.rk_valid, ks.ready, ks.done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward_zero();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
`ifdef PRESENT_KS_INVERSE_EN
        test_inverse();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/present80_key_schedule.md
# present80_key_schedule

Sequential PRESENT-80 key schedule. Captures an 80-bit master key, then emits the 32 round keys K1..K32 one at a time over a valid/ack handshake to the round datapath. It holds the evolving 80-bit key register, the round counter and the update logic (rotate, S-box, counter XOR). It sits directly upstream of the key-select mux, which takes this block's register state as its update operand.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-low.
- `key_in` input 80: master key. Sampled only on an accepted `start`.
- `start` input 1: begin a schedule. Accepted only when `ready`=1.
- `dec` input 1: direction select, sampled with `start`. Present only with `PRESENT_KS_INVERSE_EN`.
- `ready` output 1: block is idle and can accept `start`.
- `rk_valid` output 1: `rk` holds a valid round key.
- `rk` output 64: current round key, equal to `key_reg[79:16]`.
- `round` output 6: index of the round key on `rk`, from 1 to 32.
- `rk_ack` input 1: downstream consumes `rk`. A handshake completes when `rk_valid` and `rk_ack` are both high.
- `done` output 1: one-cycle pulse after the final key is acknowledged.

## Operation
- FSM states:
  - IDLE: `ready`=1, `rk_valid`=0.
  - RUN: `ready`=0, `rk_valid`=1.
- IDLE to RUN: on `start`=1, load `key_reg`←`key_in` and `rnd`←1.
- RUN with no ack: `key_reg` and `rnd` hold, so `rk` and `round` stay stable under backpressure.
- RUN with ack and `rnd`<32:
  - apply the forward update using `rc`=`rnd[4:0]`;
  - then `rnd`←`rnd`+1.
- RUN with ack and `rnd`=32: go to IDLE, pulse `done` in the next cycle, leave `key_reg` unchanged.
- Forward update, applied in this order:
  1. `k`←{`k[18:0]`, `k[79:19]`} (rotate left 61);
  2. `k[79:76]`←S(`k[79:76]`);
  3. `k[19:15]`←`k[19:15]` ^ `rc`.
- S-box S for inputs 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- `start` during RUN is ignored. It neither restarts the schedule nor samples the key.
- `rk_ack` during IDLE is ignored.
- `round` = `rnd`. The counter never wraps: 32 is terminal.

## Timing
- Reset values while `reset`=0 at a clock edge:
  - state = IDLE, `key_reg`=0, `rnd`=0;
  - `ready`=1, `rk_valid`=0, `rk`=0, `round`=0, `done`=0.
- Reset has priority over every other input. Reset during RUN aborts the schedule; no `done` pulse is issued.
- Latency:
  - `start` accepted at edge N gives K1 valid after edge N.
  - An ack at edge M gives the next key valid after edge M.
  - Full-throughput rate is one key per cycle with `rk_ack` held high.
  - A full schedule takes 32 acked cycles.
- After the final ack at edge M: `done`=1 and `ready`=1 between edges M and M+1.
- A new `start` can be accepted at edge M+1.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Configuration
- `PRESENT_KS_INVERSE_EN` defined:
  - `dec` port exists.
  - `dec`=1 at start loads `key_in` as the register state of K32 (after 31 forward updates), sets `rnd`←32, and emits K32, K31, …, K1.
  - Each ack with `rnd`>1 applies the inverse update, then `rnd`←`rnd`−1.
  - The ack at `rnd`=1 ends the schedule.
  - Inverse update, applied in this order:
    1. `k[19:15]`^=`rnd`−1;
    2. `k[79:76]`←S⁻¹(`k[79:76]`);
    3. `k`←{`k[60:0]`, `k[79:61]`} (rotate right 61).
  - `dec`=0 behaves exactly like the build without the macro.
- Not defined: no `dec` port, no S⁻¹ logic, forward-only operation.

## Test plan
- Reset is low for 2 cycles, then high → all outputs hold their reset values and `ready`=1.
- `key_in`=0, `start`, `rk_ack` held high → keys in order:
  - K1=0000000000000000;
  - K2=C000000000000000;
  - K3=5000180000000001;
  - `round` reads 1, 2, 3;
  - `done` pulses exactly once after round 32.
- Backpressure: hold `rk_ack`=0 for 5 cycles on K2 → `rk`=C000000000000000 and `round`=2 stay stable. `start` with a new key during the stall is ignored.
- Drop `reset` while `round`=10 → next cycle is IDLE with `rk_valid`=0 and no `done`. A restart with the zero key reproduces K1..K3 exactly.
- `done` cycle followed immediately by `start` → the next K1 is valid one cycle later with no dead state.
- With `PRESENT_KS_INVERSE_EN`:
  - capture the forward register state after round 32 for a random key;
  - restart with `dec`=1 and that state;
  - → emits the forward sequence exactly reversed, and round 1 equals `key_in[79:16]` of the original key.
